config_frame_writer: RTL
========================

# config_frame_writer

Column-level configuration frame writer: the producer end of the FrameData/FrameStrobe configuration protocol that the fabric tiles buffer and daisy-chain. Accepts a 32-bit configuration word stream with a valid/ready handshake, hunts for a sync word, decodes frame-write headers, assembles one frame of per-row data and fires a one-hot FrameStrobe pulse for that frame. One instance sits at the bottom of each fabric column and drives that column's FrameData and FrameStrobe inputs.

## Interface
- MaxFramesPerCol, 20: frames per column; FrameStrobe width; legal frame indices 0..MaxFramesPerCol-1.
- FrameBitsPerRow, 32: bits per row per frame; equals the configuration word width.
- NumberOfRows, 8: tile rows in the column; data words per frame.
- UserCLK  input  1  clock; all state updates on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- WriteData  input  FrameBitsPerRow  configuration word.
- WriteValid  input  1  WriteData is valid.
- WriteReady  output  1  writer accepts a word; a transfer occurs when WriteValid && WriteReady at the clock edge.
- FrameData  output  FrameBitsPerRow*NumberOfRows  assembled frame; row r occupies bits [r*FrameBitsPerRow +: FrameBitsPerRow].
- FrameStrobe  output  MaxFramesPerCol  one-hot, one-cycle commit pulse.
- ConfigBusy  output  1  high in every state except HUNT.
- ConfigError  output  1  sticky error flag.
- FrameCount  output  16  number of committed frames; wraps from 0xFFFF to 0.

## Operation
- States: HUNT, HEADER, DATA, CHECK (present only with the macro), STROBE.
- HUNT: discard accepted words until one equals 32'hFAB0_FAB1, then go to HEADER.
- HEADER: an accepted word equal to 32'hFAB0_FAB0 (desync) goes to HUNT. If bits [31:24]==8'hA5 and bits [7:0] < MaxFramesPerCol: latch the index, clear the row counter and go to DATA. Bits [23:8] are ignored. Any other word sets ConfigError and goes to HUNT.
- DATA: the k-th accepted word (k = 0..NumberOfRows-1) is written to row k of FrameData, with row 0 first. After word NumberOfRows-1 the block goes to CHECK if the macro is defined, otherwise to STROBE.
- STROBE: drive FrameStrobe[index]=1 for exactly one cycle, increment FrameCount, then return to HEADER. WriteReady=0 in STROBE.
- FrameData holds its value until it is overwritten word by word during the next DATA phase. It is stable during and after the STROBE cycle.
- ConfigError is cleared only by Reset.
- WriteReady=1 in HUNT, HEADER, DATA and CHECK.
- Reset (at any point, including mid-frame): state=HUNT; FrameData=0, FrameStrobe=0, ConfigBusy=0, ConfigError=0, FrameCount=0, WriteReady=1 in the following cycle. A partial frame is discarded and no strobe is issued.

## Timing
- All outputs are registered except WriteReady, which is decoded from the state register.
- A word accepted at edge n updates FrameData at edge n.
- FrameStrobe is high during the cycle after the edge that accepts the last data word (or the check word with the macro).
- Minimum frame period: 1 header + NumberOfRows data + 1 strobe cycle, plus 1 check cycle with the macro. This is 10 cycles at defaults without the macro.
- WriteValid gaps are legal in any state. The state, row counter and FrameData hold while no transfer occurs.
- FrameStrobe is never multi-hot and is never asserted outside STROBE.

## Configuration
- FRAME_CHECKSUM_EN defined:
  - CHECK state exists. The running XOR of the header and all data words is compared against the next accepted word.
  - Match: go to STROBE.
  - Mismatch: set ConfigError, issue no strobe, leave FrameCount unchanged, go to HUNT. FrameData keeps the unchecked data.
- FRAME_CHECKSUM_EN undefined: no CHECK state and no checksum logic; DATA goes directly to STROBE.

## Test plan
- Reset, then send FAB0_FAB1, A500_0003, words 0x11111111..0x88888888 -> FrameData row0=0x11111111 … row7=0x88888888; FrameStrobe=20'h00008 for 1 cycle; FrameCount=1; ConfigBusy=1.
- Header A500_0014 (index 20) in HEADER -> ConfigError=1, return to HUNT, no strobe; later data words are ignored until the next sync.
- Toggle WriteValid randomly during a frame -> identical FrameData and a single strobe as in the stall-free case; WriteReady=0 only in the STROBE cycle.
- Assert Reset after 4 data words -> all outputs 0, FrameStrobe never asserted; a new sync followed by a full frame commits normally.
- Two back-to-back frames (indices 0 and 19) followed by FAB0_FAB0 -> strobes 20'h00001 then 20'h80000 spaced 10 cycles apart; ConfigBusy=0 after desync.
- With FRAME_CHECKSUM_EN: a correct XOR word -> strobe; a wrong XOR word -> ConfigError=1, no strobe, FrameCount unchanged.

Source files
------------

// File: rtl/config_frame_writer.sv
// Column configuration frame writer: hunts for sync, decodes frame-write headers,
// assembles NumberOfRows words into FrameData and pulses the one-hot FrameStrobe.
// Optional FRAME_CHECKSUM_EN adds a CHECK state that verifies a running-XOR word.
module config_frame_writer #(
    parameter int MaxFramesPerCol = 20,
    parameter int FrameBitsPerRow = 32,
    parameter int NumberOfRows    = 8
) (
    input  logic                                    UserCLK,
    input  logic                                    Reset,
    input  logic [FrameBitsPerRow-1:0]              WriteData,
    input  logic                                    WriteValid,
    output logic                                    WriteReady,
    output logic [FrameBitsPerRow*NumberOfRows-1:0] FrameData,
    output logic [MaxFramesPerCol-1:0]              FrameStrobe,
    output logic                                    ConfigBusy,
    output logic                                    ConfigError,
    output logic [15:0]                             FrameCount
);
    // state    | meaning
    // HUNT     | discard words until the sync word
    // HEADER   | expect frame-write header or desync
    // DATA     | load one word per row, row 0 first
    // CHECK    | compare running XOR (FRAME_CHECKSUM_EN only)
    // STROBE   | one-cycle FrameStrobe pulse, bump FrameCount

    localparam int IDX_W = (MaxFramesPerCol > 1) ? $clog2(MaxFramesPerCol) : 1;
    localparam int ROW_W = (NumberOfRows > 1) ? $clog2(NumberOfRows) : 1;
    localparam logic [FrameBitsPerRow-1:0] SYNC_WORD   = FrameBitsPerRow'(32'hFAB0_FAB1);
    localparam logic [FrameBitsPerRow-1:0] DESYNC_WORD = FrameBitsPerRow'(32'hFAB0_FAB0);
    localparam logic [7:0]                 MAX_IDX     = 8'(MaxFramesPerCol);
    localparam logic [ROW_W-1:0]           LAST_ROW    = ROW_W'(NumberOfRows - 1);
    localparam logic [MaxFramesPerCol-1:0] STROBE_ONE  = MaxFramesPerCol'(1);

    typedef enum logic [2:0] {
        S_HUNT,
        S_HEADER,
        S_DATA,
`ifdef FRAME_CHECKSUM_EN
        S_CHECK,
`endif
        S_STROBE
    } state_t;

    state_t             state;
    logic [ROW_W-1:0]   row;
    logic [IDX_W-1:0]   frame_index;
    logic               xfer;
`ifdef FRAME_CHECKSUM_EN
    logic [FrameBitsPerRow-1:0] checksum;
`endif

    assign WriteReady = (state != S_STROBE);
    assign xfer       = WriteValid && WriteReady;

    always_ff @(posedge UserCLK) begin
        if (Reset) begin
            state       <= S_HUNT;
            row         <= '0;
            frame_index <= '0;
            FrameData   <= '0;
            FrameStrobe <= '0;
            ConfigBusy  <= 1'b0;
            ConfigError <= 1'b0;
            FrameCount  <= '0;
`ifdef FRAME_CHECKSUM_EN
            checksum    <= '0;
`endif
        end else begin
            FrameStrobe <= '0;
            case (state)
                S_HUNT: begin
                    if (xfer && WriteData == SYNC_WORD) begin
                        state      <= S_HEADER;
                        ConfigBusy <= 1'b1;
                    end
                end
                S_HEADER: begin
                    if (xfer) begin
                        if (WriteData == DESYNC_WORD) begin
                            state      <= S_HUNT;
                            ConfigBusy <= 1'b0;
                        end else if (WriteData[FrameBitsPerRow-1 -: 8] == 8'hA5 &&
                                     WriteData[7:0] < MAX_IDX) begin
                            frame_index <= WriteData[IDX_W-1:0];
                            row         <= '0;
                            state       <= S_DATA;
`ifdef FRAME_CHECKSUM_EN
                            checksum    <= WriteData;
`endif
                        end else begin
                            ConfigError <= 1'b1;
                            ConfigBusy  <= 1'b0;
                            state       <= S_HUNT;
                        end
                    end
                end
                S_DATA: begin
                    if (xfer) begin
                        FrameData[int'(row)*FrameBitsPerRow +: FrameBitsPerRow] <= WriteData;
                        row <= row + 1'b1;
`ifdef FRAME_CHECKSUM_EN
                        checksum <= checksum ^ WriteData;
                        if (row == LAST_ROW) state <= S_CHECK;
`else
                        if (row == LAST_ROW) begin
                            state       <= S_STROBE;
                            FrameStrobe <= STROBE_ONE << frame_index;
                        end
`endif
                    end
                end
`ifdef FRAME_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer) begin
                        if (WriteData == checksum) begin
                            state       <= S_STROBE;
                            FrameStrobe <= STROBE_ONE << frame_index;
                        end else begin
                            // bad frame: data stays in FrameData but is never committed
                            ConfigError <= 1'b1;
                            ConfigBusy  <= 1'b0;
                            state       <= S_HUNT;
                        end
                    end
                end
`endif
                S_STROBE: begin
                    FrameCount <= FrameCount + 16'd1;
                    state      <= S_HEADER;
                end
                default: begin
                    state      <= S_HUNT;
                    ConfigBusy <= 1'b0;
                end
            endcase
        end
    end
endmodule
